// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - single-issue hazard controller with register busy scoreboard
module issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_dec_valid,
    input  logic [6:0]  i_dec_opcode,
    input  logic [4:0]  i_dec_rd,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic        i_redirect,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_iss_ready,
    output logic        o_iss_valid,
    output logic        o_iss_illegal,
    output logic        o_dec_stall,
    output logic [31:0] o_busy
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_ILLEGAL  = 7'b1111111;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_busy;
    logic [CW-1:0]  r_count;
    logic [31:0]    w_busy_next;

    logic w_reads_rs1;
    logic w_reads_rs2;
    logic w_writes_rd;
    logic w_serial;
    logic w_illegal;
    logic w_raw;
    logic w_waw;
    logic w_limit;
    logic w_hazard;
    logic w_busy_any;
    logic w_fire;
    logic w_set;
    logic w_clr;

    always_comb begin
        w_reads_rs1 = 1'b0;
        w_reads_rs2 = 1'b0;
        w_writes_rd = 1'b0;
        case (i_dec_opcode)
            OPC_LOAD:   begin w_reads_rs1 = 1'b1; w_writes_rd = 1'b1; end
            OPC_OP_IMM: begin w_reads_rs1 = 1'b1; w_writes_rd = 1'b1; end
            OPC_STORE:  begin w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            OPC_OP:     begin w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; w_writes_rd = 1'b1; end
            OPC_BRANCH: begin w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            OPC_JALR:   begin w_reads_rs1 = 1'b1; w_writes_rd = 1'b1; end
            OPC_JAL, OPC_LUI, OPC_AUIPC: w_writes_rd = 1'b1;
            default: ;
        endcase
    end

    assign w_illegal  = (i_dec_opcode == OPC_ILLEGAL);
    assign w_serial   = (i_dec_opcode == OPC_MISC_MEM) || w_illegal;
    assign w_raw      = (w_reads_rs1 && (i_dec_rs1 != 5'd0) && r_busy[i_dec_rs1]) ||
                        (w_reads_rs2 && (i_dec_rs2 != 5'd0) && r_busy[i_dec_rs2]);
    assign w_waw      = w_writes_rd && (i_dec_rd != 5'd0) && r_busy[i_dec_rd];
    assign w_limit    = w_writes_rd && (r_count == MAX_CNT);
    assign w_hazard   = w_raw || w_waw || w_limit;
    assign w_busy_any = (r_busy != 32'd0);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state; redirect overrides every other transition
    always_comb begin
        w_state_next = r_state;
        if (i_redirect) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_dec_valid && w_serial && w_busy_any) begin
                        w_state_next = S_DRAIN;
                    end else if (w_fire && w_illegal) begin
                        w_state_next = S_HALT;
                    end
                end
                S_DRAIN: if (!w_busy_any) w_state_next = S_RUN;
                S_HALT:  w_state_next = S_HALT;
                default: w_state_next = S_RUN;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_iss_valid = 1'b0;
        if (r_state == S_RUN) begin
            o_iss_valid = i_dec_valid && !i_redirect && (w_serial ? !w_busy_any : !w_hazard);
        end
    end

    assign w_fire        = o_iss_valid && i_iss_ready;
    assign o_dec_stall   = i_dec_valid && !w_fire && !i_redirect;
    assign o_iss_illegal = w_illegal;

    // Same-register set and clear cannot coincide: WAW blocks that issue.
    assign w_set = w_fire && w_writes_rd && (i_dec_rd != 5'd0);
    assign w_clr = i_wb_valid && (i_wb_rd != 5'd0) && r_busy[i_wb_rd];

    always_comb begin
        w_busy_next = r_busy;
        if (w_clr) w_busy_next[i_wb_rd] = 1'b0;
        if (w_set) w_busy_next[i_dec_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= 32'd0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_count <= r_count + CW'(w_set) - CW'(w_clr);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed and randomized checks of issue_scoreboard
module tb_issue_scoreboard;

    localparam int MAXO = 4;

    localparam logic [6:0] LOAD = 7'b0000011, OPI = 7'b0010011, STORE = 7'b0100011;
    localparam logic [6:0] OP = 7'b0110011, BR = 7'b1100011, JALR = 7'b1100111;
    localparam logic [6:0] JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] FENCE = 7'b0001111, ILL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_valid = 1'b0;
    logic [6:0]  dec_opcode = '0;
    logic [4:0]  dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
    logic        redirect = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        iss_ready = 1'b0;
    logic        iss_valid, iss_illegal, dec_stall;
    logic [31:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    issue_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset),
        .i_dec_valid(dec_valid), .i_dec_opcode(dec_opcode),
        .i_dec_rd(dec_rd), .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
        .i_redirect(redirect), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
        .i_iss_ready(iss_ready),
        .o_iss_valid(iss_valid), .o_iss_illegal(iss_illegal),
        .o_dec_stall(dec_stall), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: set of pending destinations plus a mode flag
    bit pend[32];
    int mode;  // 0 issuing, 1 waiting for drain, 2 halted

    function automatic int n_pending();
        int n = 0;
        for (int i = 0; i < 32; i++) n += pend[i];
        return n;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    function automatic bit op_in(logic [6:0] op, int sel);
        case (sel)
            1: return op inside {LOAD, OPI, STORE, OP, BR, JALR};
            2: return op inside {STORE, OP, BR};
            3: return op inside {LOAD, OPI, OP, JALR, JAL, LUI, AUIPC};
            default: return op inside {FENCE, ILL};
        endcase
    endfunction

    function automatic bit model_issue();
        bit blocked;
        if (mode != 0 || !dec_valid || redirect) return 0;
        if (op_in(dec_opcode, 4)) return n_pending() == 0;
        blocked = (op_in(dec_opcode, 1) && dec_rs1 != 0 && pend[dec_rs1]) ||
                  (op_in(dec_opcode, 2) && dec_rs2 != 0 && pend[dec_rs2]) ||
                  (op_in(dec_opcode, 3) && dec_rd != 0 && pend[dec_rd]) ||
                  (op_in(dec_opcode, 3) && n_pending() >= MAXO);
        return !blocked;
    endfunction

    function automatic void model_commit(bit issued);
        bit any = (n_pending() != 0);
        bit fire = issued && iss_ready;
        if (wb_valid && wb_rd != 0) pend[wb_rd] = 0;
        if (fire && op_in(dec_opcode, 3) && dec_rd != 0) pend[dec_rd] = 1;
        if (redirect) mode = 0;
        else if (mode == 0 && dec_valid && op_in(dec_opcode, 4) && any) mode = 1;
        else if (mode == 0 && fire && dec_opcode == ILL) mode = 2;
        else if (mode == 1 && !any) mode = 0;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [6:0] op, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
        dec_valid = v; dec_opcode = op; dec_rd = rd; dec_rs1 = r1; dec_rs2 = r2;
    endtask

    task automatic do_reset();
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0);
        redirect = 0; wb_valid = 0; wb_rd = 0; iss_ready = 1;
        reset = 0;
        next();
        reset = 1;
        next();
    endtask

    task automatic test_reset();
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0);
        reset = 0;
        #2;
        n_tests++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_tests++; if ({iss_valid, iss_illegal, dec_stall} !== 3'b000) begin n_fail++; $display("FAIL reset_outputs: got %b want 000", {iss_valid, iss_illegal, dec_stall}); end
        do_reset();
    endtask

    task automatic test_raw_wb();
        do_reset();
        drive(1, OP, 5'd5, 5'd1, 5'd2);
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b want 1", iss_valid); end
        next();
        drive(1, OP, 5'd6, 5'd5, 5'd0);
        @(negedge clk);
        n_tests++; if (busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy: got %h want 00000020", busy); end
        n_tests++; if ({iss_valid, dec_stall} !== 2'b01) begin n_fail++; $display("FAIL raw_stall: got %b want 01", {iss_valid, dec_stall}); end
        next();
        wb_valid = 1; wb_rd = 5;
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: got %b want 0", iss_valid); end
        next();
        wb_valid = 0;
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb: got %b want 1", iss_valid); end
        next();
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if (busy !== 32'h40) begin n_fail++; $display("FAIL raw_busy_end: got %h want 00000040", busy); end
        next();
    endtask

    task automatic test_limit();
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            drive(1, OPI, 5'(r), 5'd0, 5'd0);
            @(negedge clk);
            n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL limit_fill_%0d: got %b want 1", r, iss_valid); end
            next();
        end
        drive(1, OPI, 5'd6, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if ({iss_valid, dec_stall} !== 2'b01) begin n_fail++; $display("FAIL limit_stall: got %b want 01", {iss_valid, dec_stall}); end
        next();
        wb_valid = 1; wb_rd = 2;
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL limit_wb_cycle: got %b want 0", iss_valid); end
        next();
        wb_valid = 0;
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL limit_after_wb: got %b want 1", iss_valid); end
        next();
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if (busy !== 32'h5A) begin n_fail++; $display("FAIL limit_busy: got %h want 0000005a", busy); end
    endtask

    task automatic test_reg_use();
        do_reset();
        drive(1, LUI, 5'd7, 5'd0, 5'd0);
        next();
        drive(1, STORE, 5'd0, 5'd0, 5'd7);
        @(negedge clk);
        n_tests++; if ({iss_valid, dec_stall} !== 2'b01) begin n_fail++; $display("FAIL store_rs2_stall: got %b want 01", {iss_valid, dec_stall}); end
        next();
        drive(1, OPI, 5'd8, 5'd0, 5'd7);
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL opimm_rs2_ignored: got %b want 1", iss_valid); end
        next();
        drive(1, OP, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL x0_writer: got %b want 1", iss_valid); end
        next();
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if (busy !== 32'h180) begin n_fail++; $display("FAIL x0_busy: got %h want 00000180", busy); end
    endtask

    task automatic test_fence();
        do_reset();
        drive(1, LUI, 5'd3, 5'd0, 5'd0);
        next();
        drive(1, FENCE, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if ({iss_valid, dec_stall} !== 2'b01) begin n_fail++; $display("FAIL fence_busy_hold: got %b want 01", {iss_valid, dec_stall}); end
        next();
        wb_valid = 1; wb_rd = 3;
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL fence_drain_wb: got %b want 0", iss_valid); end
        next();
        wb_valid = 0;
        @(negedge clk);
        n_tests++; if ({busy == 32'd0, iss_valid} !== 2'b10) begin n_fail++; $display("FAIL fence_drain_done: got %b want 10", {busy == 32'd0, iss_valid}); end
        next();
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL fence_issue: got %b want 1", iss_valid); end
        next();
        drive(1, LUI, 5'd3, 5'd0, 5'd0);
        next();
        drive(1, FENCE, 5'd0, 5'd0, 5'd0);
        next();
        redirect = 1;
        @(negedge clk);
        n_tests++; if ({iss_valid, dec_stall} !== 2'b00) begin n_fail++; $display("FAIL fence_redirect: got %b want 00", {iss_valid, dec_stall}); end
        next();
        redirect = 0;
        drive(1, OPI, 5'd9, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL fence_after_redirect: got %b want 1", iss_valid); end
        next();
    endtask

    task automatic test_halt();
        do_reset();
        drive(1, ILL, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        n_tests++; if ({iss_valid, iss_illegal} !== 2'b11) begin n_fail++; $display("FAIL illegal_issue: got %b want 11", {iss_valid, iss_illegal}); end
        next();
        drive(1, OP, 5'd1, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if ({iss_valid, dec_stall} !== 2'b01) begin n_fail++; $display("FAIL halt_hold_%0d: got %b want 01", i, {iss_valid, dec_stall}); end
            next();
        end
        redirect = 1;
        @(negedge clk);
        n_tests++; if ({iss_valid, dec_stall} !== 2'b00) begin n_fail++; $display("FAIL halt_redirect: got %b want 00", {iss_valid, dec_stall}); end
        next();
        redirect = 0;
        @(negedge clk);
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL halt_resume: got %b want 1", iss_valid); end
        next();
    endtask

    task automatic test_back_pressure();
        do_reset();
        iss_ready = 0;
        drive(1, OP, 5'd5, 5'd1, 5'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if ({iss_valid, dec_stall, busy == 32'd0} !== 3'b111) begin n_fail++; $display("FAIL ready_low_%0d: got %b want 111", i, {iss_valid, dec_stall, busy == 32'd0}); end
            next();
        end
        iss_ready = 1;
        drive(1, LUI, 5'd4, 5'd0, 5'd0);
        next();
        drive(1, FENCE, 5'd0, 5'd0, 5'd0);
        next();
        next();
        reset = 0;
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0);
        #2;
        n_tests++; if ({busy, iss_valid, dec_stall, iss_illegal} !== 35'd0) begin n_fail++; $display("FAIL reset_mid_drain: busy %h outs %b want 0", busy, {iss_valid, dec_stall, iss_illegal}); end
        @(negedge clk);
        reset = 1;
        drive(1, FENCE, 5'd0, 5'd0, 5'd0);
        #1;
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL reset_fsm_run: got %b want 1", iss_valid); end
        next();
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 11))
            0: return LOAD;  1: return OPI;   2: return STORE; 3: return OP;
            4: return BR;    5: return JALR;  6: return JAL;   7: return LUI;
            8: return AUIPC; 9: return FENCE; 10: return ILL;  default: return 7'b1010101;
        endcase
    endfunction

    task automatic test_random();
        bit exp_iv, exp_st;
        do_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        mode = 0;
        for (int c = 0; c < 600; c++) begin
            dec_valid  = ($urandom_range(0, 9) < 8);
            dec_opcode = pick_op();
            if (dec_opcode == ILL && $urandom_range(0, 3) != 0) dec_opcode = OP;
            dec_rd = 5'($urandom_range(0, 7));
            dec_rs1 = 5'($urandom_range(0, 7));
            dec_rs2 = 5'($urandom_range(0, 7));
            redirect  = ($urandom_range(0, 9) == 0);
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_rd     = 5'($urandom_range(0, 7));
            iss_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_iv = model_issue();
            exp_st = dec_valid && !(exp_iv && iss_ready) && !redirect;
            n_tests++; if (iss_valid !== exp_iv) begin n_fail++; $display("FAIL rnd_iss_valid c%0d: got %b want %b", c, iss_valid, exp_iv); end
            n_tests++; if (dec_stall !== exp_st) begin n_fail++; $display("FAIL rnd_dec_stall c%0d: got %b want %b", c, dec_stall, exp_st); end
            n_tests++; if (iss_illegal !== (dec_opcode == ILL)) begin n_fail++; $display("FAIL rnd_illegal c%0d: got %b want %b", c, iss_illegal, dec_opcode == ILL); end
            n_tests++; if (busy !== pend_vec()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h want %h", c, busy, pend_vec()); end
            model_commit(exp_iv);
            next();
        end
    endtask

    initial begin
        test_reset();
        test_raw_wb();
        test_limit();
        test_reg_use();
        test_fence();
        test_halt();
        test_back_pressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
